common_fifo_buffer: RTL and testbench

In-pipeline synchronous FIFO with valid/ready handshake on both sides and a power-of-two depth. It sits directly downstream of the 2-to-1 priority cross buffer and absorbs bursts from the merged stream, so the consumer can stall without back-pressuring both arbitrated producers on the same cycle. Output is registered from storage, with no combinational path from `prev_i_*` to `next_o_*`, which breaks the timing path out of the arbiter.

---
 rtl/common_fifo_buffer.sv | 43 ++++
 tb/tb_common_fifo_buffer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/common_fifo_buffer.sv
// common_fifo_buffer: power-of-two synchronous FIFO with valid/ready on both sides and registered-storage output
module common_fifo_buffer #(
  parameter int BUFFER_WIDTH      = 1,
  parameter int BUFFER_DEPTH_LOG2 = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [BUFFER_WIDTH-1:0]      prev_i_data,
  input  logic                         prev_i_valid,
  output logic                         prev_o_ready,
  output logic [BUFFER_WIDTH-1:0]      next_o_data,
  output logic                         next_o_valid,
  input  logic                         next_i_ready,
  output logic [BUFFER_DEPTH_LOG2:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);
  localparam int L = BUFFER_DEPTH_LOG2;
  logic [L:0] wptr, rptr;
  logic [BUFFER_WIDTH-1:0] mem [1<<L];
  logic fire_in, fire_out;
  assign o_count      = wptr - rptr;
  assign o_empty      = wptr == rptr;
  assign o_full       = (wptr[L-1:0] == rptr[L-1:0]) && (wptr[L] != rptr[L]);
  assign prev_o_ready = !o_full && !reset;
  assign next_o_valid = !o_empty;
  assign next_o_data  = mem[rptr[L-1:0]];
  assign fire_in      = prev_i_valid && prev_o_ready;
  assign fire_out     = next_o_valid && next_i_ready;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + {{L{1'b0}}, fire_in};
      rptr <= rptr + {{L{1'b0}}, fire_out};
    end
  end
  // storage deliberately unreset; contents are only exposed behind next_o_valid
  always_ff @(posedge clk) begin
    if (fire_in) mem[wptr[L-1:0]] <= prev_i_data;
  end
endmodule

// File: tb/tb_common_fifo_buffer.sv
// tb_common_fifo_buffer: scoreboard bench for common_fifo_buffer, D=4 W=8
module tb_common_fifo_buffer;
  localparam int D = 4;
  logic clk = 0, reset = 1;
  logic [7:0] prev_i_data = 0;
  logic prev_i_valid = 0, next_i_ready = 0;
  logic prev_o_ready, next_o_valid, o_full, o_empty;
  logic [7:0] next_o_data;
  logic [2:0] o_count;
  int checks = 0, errors = 0, pops = 0;
  logic [7:0] q[$];
  logic [7:0] exp_d;
  logic [7:0] fill [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  common_fifo_buffer #(.BUFFER_WIDTH(8), .BUFFER_DEPTH_LOG2(2)) dut (
    .clk(clk), .reset(reset),
    .prev_i_data(prev_i_data), .prev_i_valid(prev_i_valid), .prev_o_ready(prev_o_ready),
    .next_o_data(next_o_data), .next_o_valid(next_o_valid), .next_i_ready(next_i_ready),
    .o_count(o_count), .o_full(o_full), .o_empty(o_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: compares flags against the queue model, pops/compares on every handshake
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      chk("rst_valid", {31'b0, next_o_valid}, 0);
      chk("rst_ready", {31'b0, prev_o_ready}, 0);
      chk("rst_count", {29'b0, o_count}, 0);
    end else begin
      automatic int n = q.size();
      automatic bit fi = prev_i_valid && n < D;
      automatic bit fo = next_i_ready && n != 0;
      chk("count", {29'b0, o_count}, n);
      chk("count_max", {31'b0, o_count <= 3'(D)}, 1);
      chk("valid", {31'b0, next_o_valid}, {31'b0, n != 0});
      chk("ready", {31'b0, prev_o_ready}, {31'b0, n < D});
      chk("full", {31'b0, o_full}, {31'b0, n == D});
      chk("empty", {31'b0, o_empty}, {31'b0, n == 0});
      if (fo) begin
        exp_d = q.pop_front();
        pops++;
        chk("data", {24'b0, next_o_data}, {24'b0, exp_d});
      end
      if (fi) q.push_back(prev_i_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    next_i_ready = 1;
    prev_i_valid = 0;
    for (int k = 0; k < 20 && !o_empty; k++) tick();
    chk("drain_empty", {31'b0, o_empty}, 1);
  endtask

  initial begin
    int p0;
    #1;
    chk("init_valid", {31'b0, next_o_valid}, 0);
    chk("init_empty", {31'b0, o_empty}, 1);
    chk("init_full", {31'b0, o_full}, 0);
    chk("init_ready", {31'b0, prev_o_ready}, 0);
    tick(); tick();
    reset = 0;
    #1;
    chk("ready_after_rst", {31'b0, prev_o_ready}, 1);
    // fill with consumer stalled
    for (int i = 0; i < 4; i++) begin
      prev_i_valid = 1; prev_i_data = fill[i]; next_i_ready = 0;
      tick();
    end
    prev_i_valid = 0;
    chk("fill_full", {31'b0, o_full}, 1);
    chk("fill_ready", {31'b0, prev_o_ready}, 0);
    chk("fill_count", {29'b0, o_count}, 4);
    // full: simultaneous push and pop, only the pop fires
    prev_i_valid = 1; prev_i_data = 8'h55; next_i_ready = 1;
    tick();
    chk("fullpop_count", {29'b0, o_count}, 3);
    chk("fullpop_ready", {31'b0, prev_o_ready}, 1);
    tick();
    prev_i_valid = 0;
    chk("fullpop_accept", {29'b0, o_count}, 3);
    drain();
    // latency from empty
    prev_i_valid = 1; prev_i_data = 8'hA5; next_i_ready = 1;
    #1;
    chk("lat_valid_n", {31'b0, next_o_valid}, 0);
    tick();
    prev_i_valid = 0;
    chk("lat_valid_n1", {31'b0, next_o_valid}, 1);
    chk("lat_data", {24'b0, next_o_data}, 32'hA5);
    tick();
    chk("lat_count", {29'b0, o_count}, 0);
    // streaming with wrap
    p0 = pops;
    for (int i = 0; i < 20; i++) begin
      prev_i_valid = 1; prev_i_data = 8'(i); next_i_ready = 1;
      tick();
      chk("stream_count", {29'b0, o_count}, 1);
    end
    prev_i_valid = 0;
    tick();
    chk("stream_pops", pops - p0, 20);
    // asynchronous reset mid-cycle with three entries queued
    next_i_ready = 0;
    for (int i = 0; i < 3; i++) begin
      prev_i_valid = 1; prev_i_data = 8'hC0 + 8'(i);
      tick();
    end
    prev_i_valid = 0;
    chk("pre_rst_count", {29'b0, o_count}, 3);
    #2 reset = 1;
    #1;
    chk("async_valid", {31'b0, next_o_valid}, 0);
    chk("async_count", {29'b0, o_count}, 0);
    chk("async_ready", {31'b0, prev_o_ready}, 0);
    tick();
    reset = 0;
    prev_i_valid = 1; prev_i_data = 8'h77; next_i_ready = 0;
    tick();
    prev_i_valid = 0;
    chk("post_rst_count", {29'b0, o_count}, 1);
    chk("post_rst_data", {24'b0, next_o_data}, 32'h77);
    drain();
    // random back-pressure
    for (int i = 0; i < 1000; i++) begin
      prev_i_valid = 1'($urandom_range(0, 1));
      next_i_ready = 1'($urandom_range(0, 1));
      prev_i_data = 8'($urandom);
      tick();
    end
    drain();
    chk("final_queue", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
